// File: rtl/alu_in_queue_pkg.sv
// Shared ALU command definitions: field widths and the packed command record
// carried from the issue stage into the ALU input queue.
package alu_in_queue_pkg;

  localparam int OP_W       = 4;
  localparam int MOVI_W     = 2;
  localparam int CMD_DATA_W = 8;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [MOVI_W-1:0]     movi;
    logic [CMD_DATA_W-1:0] reg_a;
    logic [CMD_DATA_W-1:0] reg_b;
    logic [CMD_DATA_W-1:0] mem;
    logic [CMD_DATA_W-1:0] imm;
  } alu_cmd_t;

endpackage

// File: rtl/alu_in_queue_mem.sv
// Command storage for the ALU input queue: one synchronous write port and
// one asynchronous read port, so the head entry is visible without a read cycle.
module alu_in_queue_mem
  import alu_in_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  alu_cmd_t      wdata_i,
  input  logic [AW-1:0] raddr_i,
  output alu_cmd_t      rdata_o
);

  alu_cmd_t mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers, so stale entries are never presented and a reset net would
  // only add fan-out to every bit of the array.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_in_queue.sv
// ALU input queue: show-ahead FIFO of ALU commands with valid/ready upstream,
// act/ready downstream, synchronous flush and a wrapping issue counter.
module alu_in_queue
  import alu_in_queue_pkg::*;
#(
  parameter int DATA_WIDTH = CMD_DATA_W,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VLD,
  output logic                  IN_RDY,
  input  logic [OP_W-1:0]       IN_OP,
  input  logic [MOVI_W-1:0]     IN_MOVI,
  input  logic [DATA_WIDTH-1:0] IN_REG_A,
  input  logic [DATA_WIDTH-1:0] IN_REG_B,
  input  logic [DATA_WIDTH-1:0] IN_MEM,
  input  logic [DATA_WIDTH-1:0] IN_IMM,
  output logic                  OUT_ACT,
  output logic [OP_W-1:0]       OUT_OP,
  output logic [MOVI_W-1:0]     OUT_MOVI,
  output logic [DATA_WIDTH-1:0] OUT_REG_A,
  output logic [DATA_WIDTH-1:0] OUT_REG_B,
  output logic [DATA_WIDTH-1:0] OUT_MEM,
  output logic [DATA_WIDTH-1:0] OUT_IMM,
  input  logic                  ALU_RDY,
  input  logic                  FLUSH,
  output logic [CW-1:0]         COUNT,
  output logic [15:0]           ISSUE_CNT
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;

  logic     in_rdy, out_act, push, pop;
  alu_cmd_t wr_cmd, rd_cmd;

  // Handshake flags depend on registered occupancy only, so IN_RDY stays low
  // for a whole cycle when full even if the ALU drains an entry that cycle.
  assign in_rdy  = (count_q != FULL_CNT);
  assign out_act = (count_q != '0);
  assign push    = IN_VLD && in_rdy && !FLUSH;
  assign pop     = out_act && ALU_RDY && !FLUSH;

  assign wr_cmd = '{op: IN_OP, movi: IN_MOVI, reg_a: IN_REG_A,
                    reg_b: IN_REG_B, mem: IN_MEM, imm: IN_IMM};

  alu_in_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_cmd),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_cmd)
  );

  // NOTE: every next-state value gets its hold default first, so no path
  // through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        issue_cnt_d = issue_cnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      issue_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Fields are forced to zero when idle so the ALU never sees stale entries.
  always_comb begin
    OUT_OP    = '0;
    OUT_MOVI  = '0;
    OUT_REG_A = '0;
    OUT_REG_B = '0;
    OUT_MEM   = '0;
    OUT_IMM   = '0;
    if (out_act) begin
      OUT_OP    = rd_cmd.op;
      OUT_MOVI  = rd_cmd.movi;
      OUT_REG_A = rd_cmd.reg_a;
      OUT_REG_B = rd_cmd.reg_b;
      OUT_MEM   = rd_cmd.mem;
      OUT_IMM   = rd_cmd.imm;
    end
  end

  assign IN_RDY    = in_rdy;
  assign OUT_ACT   = out_act;
  assign COUNT     = count_q;
  assign ISSUE_CNT = issue_cnt_q;

endmodule

// File: doc/alu_in_queue.md
ALU_IN_QUEUE -- requirements
Module: alu_in_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-003 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IN_VLD  input  1  upstream command valid.
REQ-006 SHALL have port IN_RDY  output  1  queue can accept a command.
REQ-007 SHALL have ports IN_OP (4), IN_MOVI (2), IN_REG_A, IN_REG_B, IN_MEM, IN_IMM (DATA_WIDTH each), all inputs, forming the command.
REQ-008 SHALL have ports OUT_ACT (1), OUT_OP (4), OUT_MOVI (2), OUT_REG_A, OUT_REG_B, OUT_MEM, OUT_IMM (DATA_WIDTH each), all outputs, presented to the ALU input interface.
REQ-009 SHALL have port ALU_RDY  input  1  ALU accepts the presented command.
REQ-010 SHALL have port FLUSH  input  1  synchronous discard of all queued commands.
REQ-011 SHALL have port COUNT  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port ISSUE_CNT  output  16  commands issued to the ALU since reset.

Function
REQ-013 SHALL push when IN_VLD && IN_RDY at a rising edge; SHALL pop when OUT_ACT && ALU_RDY.
REQ-014 SHALL drive IN_RDY = (COUNT != DEPTH), combinational from registered occupancy only.
REQ-015 SHALL drive OUT_ACT = (COUNT != 0); OUT_* fields SHALL show the head entry (show-ahead), stable while OUT_ACT && !ALU_RDY.
REQ-016 SHALL make a command pushed into an empty queue at edge N visible with OUT_ACT=1 after edge N (one-cycle latency, no combinational bypass).
REQ-017 SHALL allow simultaneous push and pop when 0 < COUNT < DEPTH; COUNT unchanged.
REQ-018 SHALL, when full, refuse push even if a pop occurs the same cycle (IN_RDY low for whole cycle).
REQ-019 SHALL, when empty, ignore ALU_RDY (no pop, no pointer move, no ISSUE_CNT change).
REQ-020 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-021 SHALL increment ISSUE_CNT by 1 per pop, wrapping 0xFFFF -> 0x0000.
REQ-022 SHALL, on FLUSH=1, zero pointers and COUNT at that edge; FLUSH SHALL take priority over a same-cycle push and pop (neither takes effect, ISSUE_CNT unchanged).
REQ-023 SHALL drive OUT_OP/OUT_MOVI/operands to 0 when OUT_ACT=0.
REQ-024 SHALL pass all fields unmodified; no opcode checking.

Reset
REQ-025 SHALL, on RST=0, asynchronously clear pointers, COUNT=0, ISSUE_CNT=0, hence OUT_ACT=0, IN_RDY=1, OUT_* fields 0.
REQ-026 SHALL discard queued commands on reset mid-operation; storage contents need not be cleared.
REQ-027 SHALL leave reset on the first rising CLK with RST=1; a push in that cycle SHALL be accepted.

Structure
REQ-028 SHALL take opcode width (4), MOVI width (2) and typedef alu_cmd_t (op, movi, reg_a, reg_b, mem, imm) from the shared test/ALU package.
REQ-029 SHALL place the DEPTH x alu_cmd_t register file (write port, async read) in sub-module alu_in_queue_mem; pointers, counters and handshake logic stay in alu_in_queue.

Verification
REQ-030 Push OP=3, REG_A=0x12, REG_B=0x34 at edge N into empty queue, ALU_RDY=0 -> OUT_ACT=1, OUT_OP=3, OUT_REG_A=0x12 after N; held until ALU_RDY=1; ISSUE_CNT=1 after pop.
REQ-031 Push 4 commands, ALU_RDY=0 -> COUNT=4, IN_RDY=0; fifth IN_VLD with ALU_RDY=1 same cycle -> fifth not accepted, COUNT=3.
REQ-032 Continuous IN_VLD=1, ALU_RDY=1, 10 commands with IMM=0..9 -> ALU receives IMM 0..9 in order, pointers wrap twice, COUNT stays 1 in steady state.
REQ-033 COUNT=3, assert FLUSH with IN_VLD=1 and ALU_RDY=1 -> next cycle COUNT=0, OUT_ACT=0, ISSUE_CNT unchanged.
REQ-034 COUNT=2, drive RST=0 between edges -> OUT_ACT=0, COUNT=0, ISSUE_CNT=0 immediately, before next edge.
REQ-035 Preload ISSUE_CNT to 0xFFFF via 65535 pops, one more pop -> ISSUE_CNT=0x0000.
